// File: rtl/forward_buffer.sv
// forward_buffer: shift history of recent write-backs with NUM_RD bypass lookups.
// Optional same-cycle write-through: define FORWARD_BUFFER_WRITETHRU_EN.
module forward_buffer #(
  parameter int DATA_W   = 64,
  parameter int ADDR_W   = 5,
  parameter int DEPTH    = 2,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 31,
  parameter int AGE_W    = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_key,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     stall,
  input  logic                     flush,
  input  logic [NUM_RD*ADDR_W-1:0] rd_key,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_hit,
  output logic [NUM_RD*AGE_W-1:0]  rd_age
);

  localparam logic [ADDR_W-1:0] ZKEY = ADDR_W'(ZERO_REG);
`ifdef FORWARD_BUFFER_WRITETHRU_EN
  localparam int WT = 1;
`else
  localparam int WT = 0;
`endif

  logic              v_q    [DEPTH];
  logic [ADDR_W-1:0] key_q  [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];

  logic              wr_ok;
  logic              wt_act;
  logic [ADDR_W-1:0] rk;

  assign wr_ok  = wr_en && (wr_key != ZKEY);
  assign wt_act = reset && wr_ok && !flush && !stall;

  // History register: flush clears, stall holds, else shift in the write
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < DEPTH; k++) begin
        v_q[k]    <= 1'b0;
        key_q[k]  <= '0;
        data_q[k] <= '0;
      end
    end else if (flush) begin
      for (int k = 0; k < DEPTH; k++)
        v_q[k] <= 1'b0;
    end else if (!stall) begin
      for (int k = DEPTH-1; k >= 1; k--) begin
        v_q[k]    <= v_q[k-1];
        key_q[k]  <= key_q[k-1];
        data_q[k] <= data_q[k-1];
      end
      v_q[0]    <= wr_ok;
      key_q[0]  <= wr_key;
      data_q[0] <= wr_data;
    end
  end

  // Per-channel lookup; scan oldest to youngest so the youngest match wins
  always_comb begin
    rd_hit  = '0;
    rd_data = '0;
    rd_age  = '0;
    rk      = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      rk = rd_key[i*ADDR_W +: ADDR_W];
      if (rk != ZKEY) begin
        for (int k = DEPTH-1; k >= 0; k--) begin
          if (v_q[k] && key_q[k] == rk) begin
            rd_hit[i]                  = 1'b1;
            rd_data[i*DATA_W +: DATA_W] = data_q[k];
            rd_age[i*AGE_W +: AGE_W]   = AGE_W'(k + WT);
          end
        end
        if (WT == 1 && wt_act && wr_key == rk) begin
          rd_hit[i]                  = 1'b1;
          rd_data[i*DATA_W +: DATA_W] = wr_data;
          rd_age[i*AGE_W +: AGE_W]   = '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_forward_buffer.sv
// tb_forward_buffer: table-driven lookups with a queue of expected results.
// Covers reset hold, youngest-wins, dual channels, zero reg, stall/flush.
module tb_forward_buffer;

  localparam int DW = 64;
  localparam int AW = 5;
  localparam int NR = 2;
  localparam int GW = 3;
`ifdef FORWARD_BUFFER_WRITETHRU_EN
  localparam int WT = 1;
`else
  localparam int WT = 0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          wr_en;
  logic [AW-1:0] wr_key;
  logic [DW-1:0] wr_data;
  logic          stall;
  logic          flush;
  logic [NR*AW-1:0] rd_key;
  logic [NR*DW-1:0] rd_data;
  logic [NR-1:0]    rd_hit;
  logic [NR*GW-1:0] rd_age;

  forward_buffer dut (
    .clk(clk), .reset(reset),
    .wr_en(wr_en), .wr_key(wr_key), .wr_data(wr_data),
    .stall(stall), .flush(flush),
    .rd_key(rd_key), .rd_data(rd_data),
    .rd_hit(rd_hit), .rd_age(rd_age)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          h;
    logic [DW-1:0] d;
    logic [GW-1:0] a;
  } exp_t;

  typedef struct {
    logic          we;
    logic [AW-1:0] wk;
    logic [DW-1:0] wd;
    logic          st;
    logic          fl;
    logic [AW-1:0] k0;
    logic [AW-1:0] k1;
    logic          h0;
    logic [DW-1:0] d0;
    logic [GW-1:0] a0;
    logic          h1;
    logic [DW-1:0] d1;
    logic [GW-1:0] a1;
  } vec_t;

  exp_t sbq[$];
  vec_t tbl[20];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic vec_t mk(
    input logic we, input int wk, input longint wd,
    input logic st, input logic fl,
    input int k0, input int k1,
    input logic h0, input longint d0, input int a0,
    input logic h1, input longint d1, input int a1);
    vec_t v;
    v.we = we; v.wk = AW'(wk); v.wd = DW'(wd);
    v.st = st; v.fl = fl;
    v.k0 = AW'(k0); v.k1 = AW'(k1);
    v.h0 = h0; v.d0 = DW'(d0); v.a0 = GW'(a0);
    v.h1 = h1; v.d1 = DW'(d1); v.a1 = GW'(a1);
    return v;
  endfunction

  // Stored-entry expectation, adjusted for the write-through build
  function automatic exp_t adj(input vec_t v, input logic [AW-1:0] k,
                               input logic h, input logic [DW-1:0] d,
                               input logic [GW-1:0] a);
    exp_t e;
    e.h = h;
    e.d = h ? d : '0;
    e.a = h ? a + GW'(WT) : '0;
    if (WT == 1 && v.we && !v.st && !v.fl && v.wk != 5'd31 && k == v.wk) begin
      e.h = 1'b1;
      e.d = v.wd;
      e.a = '0;
    end
    return e;
  endfunction

  function automatic exp_t got(input int i);
    exp_t e;
    e.h = rd_hit[i];
    e.d = rd_data[i*DW +: DW];
    e.a = rd_age[i*GW +: GW];
    return e;
  endfunction

  function automatic exp_t mke(input logic h, input longint d, input int a);
    exp_t e;
    e.h = h; e.d = DW'(d); e.a = GW'(a);
    return e;
  endfunction

  task automatic check_ch(input string nm, input int ch);
    exp_t ex;
    exp_t ac;
    n_cmp++;
    if (sbq.size() == 0) begin
      n_bad++;
      $display("FAIL %s: scoreboard empty", nm);
    end else begin
      ex = sbq.pop_front();
      ac = got(ch);
      if (ac !== ex) begin
        n_bad++;
        $display("FAIL %s: got hit=%0b data=%h age=%0d, want hit=%0b data=%h age=%0d",
                 nm, ac.h, ac.d, ac.a, ex.h, ex.d, ex.a);
      end
    end
  endtask

  task automatic check_both(input string nm);
    check_ch({nm, ".ch0"}, 0);
    check_ch({nm, ".ch1"}, 1);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // {we,wk,wd,st,fl,k0,k1, h0,d0,a0, h1,d1,a1}: pre-edge lookup results
    tbl[0]  = mk(1, 5, 'h11, 0,0, 5, 0,  0,0,0,       0,0,0);
    tbl[1]  = mk(1, 5, 'h22, 0,0, 5, 0,  1,'h11,0,    0,0,0);
    tbl[2]  = mk(0, 0, 0,    0,0, 5, 5,  1,'h22,0,    1,'h22,0);
    tbl[3]  = mk(0, 0, 0,    0,0, 5, 5,  1,'h22,1,    1,'h22,1);
    tbl[4]  = mk(0, 0, 0,    0,0, 5, 0,  0,0,0,       0,0,0);
    tbl[5]  = mk(1, 1, 'h100,0,0, 1, 2,  0,0,0,       0,0,0);
    tbl[6]  = mk(1, 2, 'h200,0,0, 1, 2,  1,'h100,0,   0,0,0);
    tbl[7]  = mk(0, 0, 0,    0,0, 1, 2,  1,'h100,1,   1,'h200,0);
    tbl[8]  = mk(1, 31,'hFFFF,0,0, 31,2, 0,0,0,       1,'h200,1);
    tbl[9]  = mk(0, 0, 0,    0,0, 31,31, 0,0,0,       0,0,0);
    tbl[10] = mk(0, 0, 0,    0,0, 1, 2,  0,0,0,       0,0,0);
    tbl[11] = mk(1, 7, 'h77, 0,0, 7, 8,  0,0,0,       0,0,0);
    tbl[12] = mk(1, 8, 'h88, 1,0, 7, 8,  1,'h77,0,    0,0,0);
    tbl[13] = mk(1, 8, 'h88, 1,0, 7, 8,  1,'h77,0,    0,0,0);
    tbl[14] = mk(1, 8, 'h88, 1,0, 7, 8,  1,'h77,0,    0,0,0);
    tbl[15] = mk(1, 8, 'h88, 1,1, 7, 8,  1,'h77,0,    0,0,0);
    tbl[16] = mk(0, 0, 0,    0,0, 7, 8,  0,0,0,       0,0,0);
    tbl[17] = mk(1, 9, 'h99, 0,0, 0, 0,  0,0,0,       0,0,0);
    tbl[18] = mk(1, 10,'hAA, 0,1, 9, 10, 1,'h99,0,    0,0,0);
    tbl[19] = mk(0, 0, 0,    0,0, 9, 10, 0,0,0,       0,0,0);

    reset   = 1'b0;
    wr_en   = 1'b1;
    wr_key  = 5'd3;
    wr_data = 64'hAA;
    stall   = 1'b0;
    flush   = 1'b0;
    rd_key  = {5'd3, 5'd3};

    // Reset held low: writes must not appear on the outputs
    for (int c = 0; c < 3; c++) begin
      step();
      sbq.push_back(mke(0, 0, 0));
      sbq.push_back(mke(0, 0, 0));
      check_both($sformatf("rst_hold%0d", c));
    end
    reset = 1'b1;
    wr_en = 1'b0;
    #1;
    sbq.push_back(mke(0, 0, 0));
    sbq.push_back(mke(0, 0, 0));
    check_both("rst_release");
    step();

    for (int i = 0; i < 20; i++) begin
      wr_en   = tbl[i].we;
      wr_key  = tbl[i].wk;
      wr_data = tbl[i].wd;
      stall   = tbl[i].st;
      flush   = tbl[i].fl;
      rd_key  = {tbl[i].k1, tbl[i].k0};
      sbq.push_back(adj(tbl[i], tbl[i].k0, tbl[i].h0, tbl[i].d0, tbl[i].a0));
      sbq.push_back(adj(tbl[i], tbl[i].k1, tbl[i].h1, tbl[i].d1, tbl[i].a1));
      #1;
      check_both($sformatf("row%0d", i));
      step();
    end

    // Mid-stream async reset empties a populated history
    stall   = 1'b0;
    flush   = 1'b0;
    wr_en   = 1'b1;
    wr_key  = 5'd4;
    wr_data = 64'h44;
    rd_key  = {5'd0, 5'd4};
    step();
    wr_en = 1'b0;
    #1;
    sbq.push_back(mke(1, 'h44, WT));
    sbq.push_back(mke(0, 0, 0));
    check_both("pre_rst");
    reset = 1'b0;
    #1;
    sbq.push_back(mke(0, 0, 0));
    sbq.push_back(mke(0, 0, 0));
    check_both("mid_rst");
    reset = 1'b1;
    wr_en   = 1'b1;
    wr_key  = 5'd6;
    wr_data = 64'h66;
    rd_key  = {5'd4, 5'd0};
    step();
    wr_en  = 1'b0;
    rd_key = {5'd4, 5'd6};
    #1;
    sbq.push_back(mke(1, 'h66, WT));
    sbq.push_back(mke(0, 0, 0));
    check_both("post_rst");
    step();
    step();

`ifdef FORWARD_BUFFER_WRITETHRU_EN
    wr_en   = 1'b1;
    wr_key  = 5'd4;
    wr_data = 64'h44;
    rd_key  = {5'd4, 5'd4};
    #1;
    sbq.push_back(mke(1, 'h44, 0));
    sbq.push_back(mke(1, 'h44, 0));
    check_both("wt_same");
    step();
    wr_en = 1'b0;
    #1;
    sbq.push_back(mke(1, 'h44, 1));
    sbq.push_back(mke(1, 'h44, 1));
    check_both("wt_after");
`endif

    if (sbq.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL sb_drain: %0d left, want 0", sbq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
